// File: rtl/peripheral_spi_if.sv
// J1 I/O bus port set shared by the SoC peripherals: write data, chip
// select, register address, read/write strobes and the read-data return.
`timescale 1ns/1ps
interface peripheral_spi_if;
  logic [15:0] d_in;
  logic        cs;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] d_out;

  // Bus side (J1 core / SoC decoder).
  modport master (output d_in, cs, addr, rd, wr, input d_out);
  // Peripheral side.
  modport slave  (input d_in, cs, addr, rd, wr, output d_out);
endinterface

// File: rtl/peripheral_spi.sv
// SPI master peripheral for the J1 I/O bus: mode 0, 8-bit frames, MSB first.
// Software writes TXDATA to launch a frame, polls STATUS, reads RXDATA.
// spi_ss_n is purely software-driven through CTRL.SS_N.
`timescale 1ns/1ps
module peripheral_spi #(
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic             clk,
  input  logic             rst,
  peripheral_spi_if.slave  bus,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_ss_n
);

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h2;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h6;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t      state_q,    state_d;
  logic [7:0]  shift_q,    shift_d;
  logic        mosi_q,     mosi_d;
  logic        sclk_q,     sclk_d;
  logic [7:0]  div_cnt_q,  div_cnt_d;
  logic [3:0]  edge_cnt_q, edge_cnt_d;
  logic [7:0]  rx_q,       rx_d;
  logic        done_q,     done_d;
  logic        wcol_q,     wcol_d;
  logic [7:0]  div_q,      div_d;
  logic        ss_n_q,     ss_n_d;

  logic        wr_en;
  logic        rd_en;
  logic        tx_wr;
  logic        busy;
  logic        div_wrap;
  logic [15:0] rd_data;

  // Upper write-data bits have no destination in this register map.
  logic        unused_d_in;
  assign unused_d_in = ^bus.d_in[15:9];

  assign wr_en    = bus.cs & bus.wr;
  assign rd_en    = bus.cs & bus.rd;
  assign tx_wr    = wr_en && (bus.addr == ADDR_TXDATA);
  assign busy     = (state_q == XFER);
  // >= rather than == so that lowering DIV below the running count mid-period
  // still produces a wrap instead of running the counter round to 255.
  assign div_wrap = (div_cnt_q >= div_q);

  // Next-state and datapath: bus side effects, then the shift engine.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned
    // (which would infer a latch); the branches below override as needed.
    state_d    = state_q;
    shift_d    = shift_q;
    mosi_d     = mosi_q;
    sclk_d     = sclk_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    rx_d       = rx_q;
    done_d     = done_q;
    wcol_d     = wcol_q;
    div_d      = div_q;
    ss_n_d     = ss_n_q;

    // Clear-on-read comes first so a same-cycle set further down wins.
    if (rd_en && (bus.addr == ADDR_RXDATA)) done_d = 1'b0;
    if (rd_en && (bus.addr == ADDR_STATUS)) wcol_d = 1'b0;

    if (wr_en && (bus.addr == ADDR_CTRL)) begin
      div_d  = bus.d_in[7:0];
      ss_n_d = bus.d_in[8];
    end

    unique case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        if (tx_wr) begin
          shift_d    = bus.d_in[7:0];
          mosi_d     = bus.d_in[7];
          div_cnt_d  = 8'd0;
          edge_cnt_d = 4'd0;
          state_d    = XFER;
        end
      end

      XFER: begin
        if (tx_wr) wcol_d = 1'b1;
        if (div_wrap) begin
          div_cnt_d  = 8'd0;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (!sclk_q) begin
            // Rising sclk: shift left and capture MISO into bit 0, so the
            // next outgoing bit lands in bit 7 ready for the falling edge.
            shift_d = {shift_q[6:0], spi_miso};
          end else if (edge_cnt_q == 4'd15) begin
            // Eighth falling edge ends the frame; shift holds the rx byte.
            state_d = IDLE;
            rx_d    = shift_q;
            done_d  = 1'b1;
          end else begin
            mosi_d = shift_q[7];
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= 8'd0;
      mosi_q     <= 1'b0;
      sclk_q     <= 1'b0;
      div_cnt_q  <= 8'd0;
      edge_cnt_q <= 4'd0;
      rx_q       <= 8'd0;
      done_q     <= 1'b0;
      wcol_q     <= 1'b0;
      div_q      <= DIV_RESET;
      ss_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      rx_q       <= rx_d;
      done_q     <= done_d;
      wcol_q     <= wcol_d;
      div_q      <= div_d;
      ss_n_q     <= ss_n_d;
    end
  end

  // Combinational register read mux, forced to zero when not selected.
  always_comb begin
    rd_data = 16'h0000;
    if (bus.cs) begin
      unique case (bus.addr)
        ADDR_RXDATA: rd_data = {8'h00, rx_q};
        ADDR_STATUS: rd_data = {13'd0, wcol_q, done_q, busy};
        ADDR_CTRL:   rd_data = {7'd0, ss_n_q, div_q};
        default:     rd_data = 16'h0000;
      endcase
    end
  end

  assign bus.d_out = rd_data;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_ss_n  = ss_n_q;

endmodule

// File: tb/tb_peripheral_spi.sv
// Scoreboard bench for peripheral_spi: stimulus queues expected register
// reads and MOSI bits; a monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_peripheral_spi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sclk, spi_mosi, spi_miso, spi_ss_n;

  peripheral_spi_if bus ();

  peripheral_spi #(.DIV_RESET(8'd3)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  logic    mosi_q[$];

  int   total = 0;
  int   bad = 0;
  int   rise_cnt = 0;
  logic sclk_prev = 1'b0;

  // MISO source: loopback of MOSI, or a mode-0 slave that presents its next
  // bit after each falling sclk (first bit ready before the first rise).
  logic        loop_en = 1'b1;
  logic [7:0]  slave_byte = 8'h00;
  int          fall_cnt = 0;
  int          fall_base = 0;
  logic [31:0] fidx;

  always @(negedge spi_sclk) fall_cnt++;

  assign fidx     = fall_cnt - fall_base;
  assign spi_miso = loop_en ? spi_mosi
                  : ((fidx < 32'd8) ? slave_byte[3'd7 - fidx[2:0]] : 1'b0);

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling clk edge, away from the active edge.
  always @(negedge clk) begin
    rd_exp_t e;
    logic    eb;
    if (spi_sclk && !sclk_prev) begin
      rise_cnt++;
      if (mosi_q.size() > 0) begin
        eb = mosi_q.pop_front();
        check("mosi_at_rise", {15'd0, spi_mosi}, {15'd0, eb});
      end
    end
    sclk_prev = spi_sclk;
    if (bus.cs && bus.rd) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: addr %h got %h expected none", bus.addr, bus.d_out);
      end else begin
        e = rd_q.pop_front();
        check(e.name, bus.d_out, e.exp);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(logic [3:0] a, logic [15:0] d);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
    tick(1);
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic rd_reg(logic [3:0] a, logic [15:0] exp, string name);
    rd_exp_t e;
    e.name = name;
    e.exp  = exp;
    rd_q.push_back(e);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
    tick(1);
    bus.cs = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic push_byte(logic [7:0] b);
    for (int i = 7; i >= 0; i--) mosi_q.push_back(b[i]);
  endtask

  // Launch a frame and poll STATUS every cycle: busy for exactly
  // 16*(div+1) reads, then done; then RXDATA and the cleared STATUS.
  task automatic run_frame(logic [7:0] tx, int div, logic [7:0] rx_exp, string tag);
    int r0;
    push_byte(tx);
    r0 = rise_cnt;
    wr_reg(4'h0, {8'h00, tx});
    for (int k = 0; k < 16 * (div + 1); k++) rd_reg(4'h4, 16'h0001, {tag, "_busy"});
    rd_reg(4'h4, 16'h0002, {tag, "_done"});
    check({tag, "_rises"}, 16'(rise_cnt - r0), 16'd8);
    rd_reg(4'h2, {8'h00, rx_exp}, {tag, "_rxdata"});
    rd_reg(4'h4, 16'h0000, {tag, "_status_clr"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 4'h0; bus.d_in = 16'h0000;

    // Reset defaults.
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_sclk", {15'd0, spi_sclk}, 16'd0);
    check("rst_ss_n", {15'd0, spi_ss_n}, 16'd1);
    check("rst_mosi", {15'd0, spi_mosi}, 16'd0);
    rd_reg(4'h6, 16'h0103, "rst_ctrl");
    rd_reg(4'h4, 16'h0000, "rst_status");
    rd_reg(4'h2, 16'h0000, "rst_rxdata");

    // Bus isolation: unselected write, unselected read, unmapped addresses.
    bus.cs = 1'b0; bus.wr = 1'b1; bus.addr = 4'h0; bus.d_in = 16'h00FF;
    tick(1);
    bus.wr = 1'b0;
    tick(2);
    rd_reg(4'h4, 16'h0000, "iso_no_start");
    check("iso_sclk", {15'd0, spi_sclk}, 16'd0);
    bus.addr = 4'h6; bus.rd = 1'b1;
    #1;
    check("iso_cs0_dout", bus.d_out, 16'h0000);
    bus.rd = 1'b0;
    tick(1);
    rd_reg(4'hE, 16'h0000, "unmapped_rd");
    rd_reg(4'h0, 16'h0000, "txdata_rd");
    wr_reg(4'h8, 16'h00FF);
    rd_reg(4'h6, 16'h0103, "unmapped_wr_ignored");

    // Loopback at DIV=0.
    wr_reg(4'h6, 16'h0000);
    check("ss_n_low", {15'd0, spi_ss_n}, 16'd0);
    rd_reg(4'h6, 16'h0000, "ctrl_div0");
    loop_en = 1'b1;
    run_frame(8'hA5, 0, 8'hA5, "loop");

    // Slave model at DIV=3: master sends C3, slave returns 3C.
    wr_reg(4'h6, 16'h0003);
    loop_en    = 1'b0;
    slave_byte = 8'h3C;
    fall_base  = fall_cnt;
    run_frame(8'hC3, 3, 8'h3C, "slave");

    // Collision during a DIV=0 loopback frame of 0x55.
    wr_reg(4'h6, 16'h0000);
    loop_en = 1'b1;
    push_byte(8'h55);
    r0 = rise_cnt;
    wr_reg(4'h0, 16'h0055);
    tick(4);
    wr_reg(4'h0, 16'h00FF);
    rd_reg(4'h4, 16'h0005, "wcol_set");
    rd_reg(4'h4, 16'h0001, "wcol_cleared");
    tick(10);
    rd_reg(4'h4, 16'h0002, "wcol_frame_done");
    rd_reg(4'h2, 16'h0055, "wcol_rx_intact");
    check("wcol_rises", 16'(rise_cnt - r0), 16'd8);
    rd_reg(4'h4, 16'h0000, "wcol_status_clr");

    // Reset mid-transfer (RXDATA starts from its reset value).
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    wr_reg(4'h6, 16'h0000);
    wr_reg(4'h0, 16'h00A5);
    tick(6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_sclk", {15'd0, spi_sclk}, 16'd0);
    rd_reg(4'h4, 16'h0000, "abort_status");
    rd_reg(4'h2, 16'h0000, "abort_rxdata");
    rd_reg(4'h6, 16'h0103, "abort_ctrl");

    // Follow-up frame; an RXDATA read in the done-set cycle must not clear done.
    wr_reg(4'h6, 16'h0000);
    push_byte(8'h96);
    r0 = rise_cnt;
    wr_reg(4'h0, 16'h0096);
    for (int k = 0; k < 15; k++) rd_reg(4'h4, 16'h0001, "post_busy");
    rd_reg(4'h2, 16'h0000, "post_rx_same_cycle");
    rd_reg(4'h4, 16'h0002, "post_done_wins");
    check("post_rises", 16'(rise_cnt - r0), 16'd8);
    rd_reg(4'h2, 16'h0096, "post_rxdata");
    rd_reg(4'h4, 16'h0000, "post_status_clr");

    // Software raises slave select again.
    wr_reg(4'h6, 16'h0100);
    check("ss_n_high", {15'd0, spi_ss_n}, 16'd1);

    tick(2);
    check("rd_queue_drained", 16'(rd_q.size()), 16'd0);
    check("mosi_queue_drained", 16'(mosi_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
